// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// mem_access_ctrl_if : data-memory request/response bundle
// Rev 1.0
// ============================================================================

interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_size,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_size,
    output mem_ack,
    output mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// mem_access_ctrl : MEM-stage controller, one outstanding data-memory access
// Rev 1.0
// ============================================================================

module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [63:0]        ALUresult,
  input  logic [63:0]        WriteData,
  input  logic [4:0]         Rd,
  input  logic [1:0]         WB,
  input  logic [4:0]         M,
  mem_access_ctrl_if.master  bus,
  output logic               stall,
  output logic               wb_valid,
  output logic [63:0]        wb_data,
  output logic [4:0]         wb_Rd,
  output logic [1:0]         wb_WB,
  output logic               fault
);

  localparam int unsigned        c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [63:0]        r_addr;
  logic [63:0]        r_wdata;
  logic [1:0]         r_size;
  logic               r_we;
  logic [4:0]         r_rd;
  logic [1:0]         r_wb;
  logic [c_cnt_w-1:0] r_cnt;

  logic               r_wb_valid;
  logic [63:0]        r_wb_data;
  logic [4:0]         r_wb_rd;
  logic [1:0]         r_wb_wb;
  logic               r_fault;

  logic               w_mem_op;
  logic               w_misaligned;
  logic               w_illegal;
  logic               w_stall;
  logic               w_accept;
  logic               w_alu_wb;
  logic               w_done;
  logic               w_fault_now;
  logic               w_timeout;
  logic [63:0]        w_load_data;

  assign w_mem_op = valid & (M[0] | M[1]);

  always_comb begin
    w_misaligned = 1'b0;
    case (M[3:2])
      2'b01:   w_misaligned = ALUresult[0];
      2'b10:   w_misaligned = |ALUresult[1:0];
      2'b11:   w_misaligned = |ALUresult[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_illegal = (M[0] & M[1]) | M[4] | w_misaligned;

  always_comb begin
    w_load_data = bus.mem_rdata;
    case (r_size)
      2'b00:   w_load_data = {56'd0, bus.mem_rdata[7:0]};
      2'b01:   w_load_data = {48'd0, bus.mem_rdata[15:0]};
      2'b10:   w_load_data = {32'd0, bus.mem_rdata[31:0]};
      default: w_load_data = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // An ack arriving in the threshold cycle takes priority over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_accept    = 1'b0;
    w_alu_wb    = 1'b0;
    w_done      = 1'b0;
    w_fault_now = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          w_stall = 1'b1;
          if (w_illegal) begin
            w_fault_now = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_BUSY;
          end
        end else if (valid) begin
          w_alu_wb = 1'b1;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (bus.mem_ack) begin
          w_stall     = 1'b0;
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_cnt_last) begin
          w_stall     = 1'b0;
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_we       <= 1'b0;
      r_rd       <= '0;
      r_wb       <= '0;
      r_cnt      <= '0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_wb_rd    <= '0;
      r_wb_wb    <= '0;
      r_fault    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= ALUresult;
        r_wdata <= WriteData;
        r_size  <= M[3:2];
        r_we    <= M[0];
        r_rd    <= Rd;
        r_wb    <= WB;
        r_cnt   <= '0;
      end else if (r_state == S_BUSY && !bus.mem_ack && r_cnt != c_cnt_last) begin
        r_cnt <= r_cnt + 1'b1;
      end

      r_wb_valid <= w_alu_wb | w_done | w_fault_now | w_timeout;
      r_fault    <= w_fault_now | w_timeout;

      if (w_alu_wb) begin
        r_wb_data <= ALUresult;
        r_wb_rd   <= Rd;
        r_wb_wb   <= WB;
      end else if (w_done) begin
        r_wb_data <= r_we ? 64'd0 : w_load_data;
        r_wb_rd   <= r_rd;
        r_wb_wb   <= r_wb;
      end else if (w_fault_now) begin
        r_wb_data <= '0;
        r_wb_rd   <= Rd;
        r_wb_wb   <= 2'b00;
      end else if (w_timeout) begin
        r_wb_data <= '0;
        r_wb_rd   <= r_rd;
        r_wb_wb   <= 2'b00;
      end
    end
  end

  // stall is combinational from live inputs, so it must be forced low in reset.
  assign stall         = rst & w_stall;
  assign bus.mem_req   = (r_state == S_BUSY);
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_size  = r_size;

  assign wb_valid = r_wb_valid;
  assign wb_data  = r_wb_data;
  assign wb_Rd    = r_wb_rd;
  assign wb_WB    = r_wb_wb;
  assign fault    = r_fault;

endmodule

`default_nettype wire
